nipcb_spi_engine: RTL and testbench

//   3-wire SPI master that drives the NI PCB serial pins: ni_csn_hp_dac, ni_csn_adc, ni_sclk and ni_sdio.

---
 rtl/nipcb_pkg.sv | 14 +
 rtl/nipcb_sclk_gen.sv | 42 ++++
 rtl/nipcb_spi_engine.sv | 171 +++++++++++++++++
 tb/tb_nipcb_spi_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nipcb_pkg.sv
// Shared types and sizing for the NI PCB 3-wire SPI engine.
package nipcb_pkg;

    localparam int NIPCB_MAX_BITS = 16;
    localparam int NIPCB_LEN_W    = 5;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_W, SHIFT_R, HOLD, GAP} state_e;
    typedef enum logic {DEV_DAC = 1'b0, DEV_ADC = 1'b1} dev_e;

    function automatic logic [NIPCB_LEN_W-1:0] clamp_len(input logic [NIPCB_LEN_W-1:0] len);
        return (len > NIPCB_LEN_W'(NIPCB_MAX_BITS)) ? NIPCB_LEN_W'(NIPCB_MAX_BITS) : len;
    endfunction

endpackage

// File: rtl/nipcb_sclk_gen.sv
// Mode-0 SCLK divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
module nipcb_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(CLK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Strobes flag the CLK edge on which sclk_q is about to toggle.
    assign sclk_o     = sclk_q;
    assign rise_stb_o = en_i & wrap & ~sclk_q;
    assign fall_stb_o = en_i & wrap & sclk_q;

endmodule

// File: rtl/nipcb_spi_engine.sv
// 3-wire SPI master for the NI PCB DAC/ADC pins; one command at a time.
// Optional sticky interrupt output enabled by defining NIPCB_SPI_IRQ_EN.
module nipcb_spi_engine
    import nipcb_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_dev,
    input  logic [NIPCB_MAX_BITS-1:0] cmd_wdata,
    input  logic [NIPCB_LEN_W-1:0]    cmd_wlen,
    input  logic [NIPCB_LEN_W-1:0]    cmd_rlen,
    output logic                      rsp_valid,
    output logic [NIPCB_MAX_BITS-1:0] rsp_data,
    output logic                      busy,
    output logic                      ni_csn_hp_dac,
    output logic                      ni_csn_adc,
    output logic                      ni_sclk,
    output logic                      ni_sdio_o,
    output logic                      ni_sdio_oe,
    input  logic                      ni_sdio_i
`ifdef NIPCB_SPI_IRQ_EN
    ,
    output logic                      irq,
    input  logic                      irq_clr
`endif
);

    state_e                    state_q;
    logic [NIPCB_LEN_W-1:0]    wlen_q, rlen_q, bit_cnt_q;
    logic [NIPCB_MAX_BITS-1:0] wsh_q, rsh_q, rsp_data_q;
    logic [15:0]               tmr_q;
    logic                      csn_dac_q, csn_adc_q, sdio_o_q, oe_q, rsp_valid_q;
    logic [NIPCB_LEN_W-1:0]    wlen_c, rlen_c;
    logic                      sclk_en, rise_stb, fall_stb;

    assign wlen_c  = clamp_len(cmd_wlen);
    assign rlen_c  = clamp_len(cmd_rlen);
    assign sclk_en = (state_q == SHIFT_W) || (state_q == SHIFT_R);

    nipcb_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .en_i       (sclk_en),
        .sclk_o     (ni_sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            wlen_q      <= '0;
            rlen_q      <= '0;
            bit_cnt_q   <= '0;
            wsh_q       <= '0;
            rsh_q       <= '0;
            rsp_data_q  <= '0;
            tmr_q       <= '0;
            csn_dac_q   <= 1'b1;
            csn_adc_q   <= 1'b1;
            sdio_o_q    <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            // NOTE: default first so the response strobe is exactly one cycle wide.
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    wlen_q <= wlen_c;
                    rlen_q <= rlen_c;
                    wsh_q  <= cmd_wdata << (NIPCB_LEN_W'(NIPCB_MAX_BITS) - wlen_c);
                    rsh_q  <= '0;
                    if (wlen_c == '0 && rlen_c == '0) begin
                        state_q     <= GAP;
                        tmr_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        state_q   <= SETUP;
                        tmr_q     <= 16'(CS_SETUP - 1);
                        csn_dac_q <= (dev_e'(cmd_dev) != DEV_DAC);
                        csn_adc_q <= (dev_e'(cmd_dev) != DEV_ADC);
                    end
                end
                SETUP: if (tmr_q == '0) begin
                    if (wlen_q != '0) begin
                        state_q   <= SHIFT_W;
                        bit_cnt_q <= wlen_q;
                        oe_q      <= 1'b1;
                        sdio_o_q  <= wsh_q[NIPCB_MAX_BITS-1];
                        wsh_q     <= wsh_q << 1;
                    end else begin
                        state_q   <= SHIFT_R;
                        bit_cnt_q <= rlen_q;
                    end
                end else begin
                    tmr_q <= tmr_q - 16'd1;
                end
                // Data advances on SCLK falling edges so it only moves while SCLK is low.
                SHIFT_W: if (fall_stb) begin
                    if (bit_cnt_q == NIPCB_LEN_W'(1)) begin
                        oe_q     <= 1'b0;
                        sdio_o_q <= 1'b0;
                        if (rlen_q != '0) begin
                            state_q   <= SHIFT_R;
                            bit_cnt_q <= rlen_q;
                        end else begin
                            state_q <= HOLD;
                            tmr_q   <= 16'(CS_HOLD - 1);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - NIPCB_LEN_W'(1);
                        sdio_o_q  <= wsh_q[NIPCB_MAX_BITS-1];
                        wsh_q     <= wsh_q << 1;
                    end
                end
                SHIFT_R: begin
                    if (rise_stb) rsh_q <= {rsh_q[NIPCB_MAX_BITS-2:0], ni_sdio_i};
                    if (fall_stb) begin
                        if (bit_cnt_q == NIPCB_LEN_W'(1)) begin
                            state_q <= HOLD;
                            tmr_q   <= 16'(CS_HOLD - 1);
                        end else begin
                            bit_cnt_q <= bit_cnt_q - NIPCB_LEN_W'(1);
                        end
                    end
                end
                HOLD: if (tmr_q == '0) begin
                    state_q     <= GAP;
                    csn_dac_q   <= 1'b1;
                    csn_adc_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= rsh_q;
                    tmr_q       <= 16'(CS_IDLE - 1);
                end else begin
                    tmr_q <= tmr_q - 16'd1;
                end
                GAP: if (tmr_q == '0) state_q <= IDLE;
                     else             tmr_q   <= tmr_q - 16'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign ni_csn_hp_dac = csn_dac_q;
    assign ni_csn_adc    = csn_adc_q;
    assign ni_sdio_o     = sdio_o_q;
    assign ni_sdio_oe    = oe_q;

`ifdef NIPCB_SPI_IRQ_EN
    // The response cycle is visible on irq immediately and outranks a clear in that cycle.
    logic irq_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) irq_q <= 1'b0;
        else       irq_q <= rsp_valid_q | (irq_q & ~irq_clr);
    end
    assign irq = irq_q | rsp_valid_q;
`endif

endmodule

// File: tb/tb_nipcb_spi_engine.sv
// Self-checking bench for nipcb_spi_engine: vector table, corner sequences, random commands.
module tb_nipcb_spi_engine;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 3;

    typedef struct {
        logic        dev;
        logic [15:0] wdata;
        logic [4:0]  wlen;
        logic [4:0]  rlen;
        logic [15:0] slave;
        int          exp_low;
        int          exp_rises;
        logic [15:0] exp_wbits;
        logic [15:0] exp_rsp;
    } vec_t;

    typedef struct {
        int          dac_low;
        int          adc_low;
        int          rises;
        int          oe_bad;
        int          chg_bad;
        int          ready_bad;
        int          first_low;
        int          last_low;
        logic [15:0] wbits;
        logic [15:0] rsp;
        bit          done;
    } obs_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dev = 1'b0;
    logic [15:0] cmd_wdata = '0;
    logic [4:0]  cmd_wlen = '0;
    logic [4:0]  cmd_rlen = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        ni_csn_hp_dac, ni_csn_adc, ni_sclk, ni_sdio_o, ni_sdio_oe;
    logic        ni_sdio_i = 1'b0;
`ifdef NIPCB_SPI_IRQ_EN
    logic        irq;
    logic        irq_clr = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

    nipcb_spi_engine #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
        .cmd_wdata(cmd_wdata), .cmd_wlen(cmd_wlen), .cmd_rlen(cmd_rlen),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .ni_csn_hp_dac(ni_csn_hp_dac), .ni_csn_adc(ni_csn_adc), .ni_sclk(ni_sclk),
        .ni_sdio_o(ni_sdio_o), .ni_sdio_oe(ni_sdio_oe), .ni_sdio_i(ni_sdio_i)
`ifdef NIPCB_SPI_IRQ_EN
        , .irq(irq), .irq_clr(irq_clr)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input logic [4:0] len);
        return (int'(len) > 16) ? 16 : int'(len);
    endfunction

    // Reference built from the protocol rules: timing formula, bit counts, masks.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        int wl = clamp(v.wlen);
        int rl = clamp(v.rlen);
        int n  = wl + rl;
        e.exp_low   = (n == 0) ? 0 : CS_SETUP + 2 * CLK_DIV * n + CS_HOLD;
        e.exp_rises = n;
        e.exp_wbits = 16'(32'(v.wdata) & ((32'd1 << wl) - 1));
        e.exp_rsp   = 16'(32'(v.slave) & ((32'd1 << rl) - 1));
        return e;
    endfunction

    // Called on a falling CLK edge; returns on the falling edge where rsp_valid is seen.
    task automatic run_cmd(input vec_t v, input bit keep, output obs_t o);
        int  guard;
        int  wl, rl, r;
        bit  prev_sclk, prev_sdio;
        o = '{default: 0};
        o.first_low = -1;
        wl = clamp(v.wlen);
        rl = clamp(v.rlen);
        cmd_dev = v.dev; cmd_wdata = v.wdata; cmd_wlen = v.wlen; cmd_rlen = v.rlen;
        cmd_valid = 1'b1;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge CLK);
        if (!keep) cmd_valid = 1'b0;
        prev_sclk = 1'b0;
        prev_sdio = ni_sdio_o;
        for (int i = 0; i < 3000; i++) begin
            if (ni_csn_hp_dac === 1'b0) o.dac_low++;
            if (ni_csn_adc === 1'b0) o.adc_low++;
            if (ni_csn_hp_dac === 1'b0 || ni_csn_adc === 1'b0) begin
                if (o.first_low < 0) o.first_low = cyc;
                o.last_low = cyc;
            end
            if (cmd_ready !== 1'b0) o.ready_bad++;
            if (ni_sclk && prev_sclk && ni_sdio_o !== prev_sdio) o.chg_bad++;
            if (ni_sclk && !prev_sclk) begin
                if (o.rises < wl) begin
                    o.wbits = {o.wbits[14:0], ni_sdio_o};
                    if (ni_sdio_oe !== 1'b1) o.oe_bad++;
                end else if (ni_sdio_oe !== 1'b0) begin
                    o.oe_bad++;
                end
                o.rises++;
            end
            prev_sclk = ni_sclk;
            prev_sdio = ni_sdio_o;
            r = o.rises - wl;
            ni_sdio_i = (r >= 0 && r < rl) ? v.slave[rl - 1 - r] : 1'b0;
            if (rsp_valid === 1'b1) begin
                o.rsp  = rsp_data;
                o.done = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!o.done) check("rsp_timeout", 0, 1);
    endtask

    task automatic check_obs(input string tag, input vec_t e, input obs_t o);
        check({tag, " sel_csn_low"},  e.dev ? o.adc_low : o.dac_low, e.exp_low);
        check({tag, " other_csn_low"}, e.dev ? o.dac_low : o.adc_low, 0);
        check({tag, " rises"},         o.rises, e.exp_rises);
        check({tag, " wbits"},         o.wbits, e.exp_wbits);
        check({tag, " rsp_data"},      o.rsp, e.exp_rsp);
        check({tag, " oe_bad"},        o.oe_bad, 0);
        check({tag, " sdio_chg_high"}, o.chg_bad, 0);
        check({tag, " ready_low"},     o.ready_bad, 0);
    endtask

    vec_t tbl [8];
    vec_t v, e;
    obs_t o, o1, o2;
    int   base, gap, n_rise;

    initial begin
        tbl[0] = '{1'b0, 16'hA5C3, 5'd16, 5'd0,  16'h0000,  68, 16, 16'hA5C3, 16'h0000};
        tbl[1] = '{1'b1, 16'h0081, 5'd8,  5'd16, 16'h1234, 100, 24, 16'h0081, 16'h1234};
        tbl[2] = '{1'b0, 16'h0000, 5'd0,  5'd0,  16'hFFFF,   0,  0, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 16'hFFFF, 5'd20, 5'd0,  16'h0000,  68, 16, 16'hFFFF, 16'h0000};
        tbl[4] = '{1'b1, 16'h0003, 5'd2,  5'd3,  16'h0005,  24,  5, 16'h0003, 16'h0005};
        tbl[5] = '{1'b0, 16'h0001, 5'd1,  5'd1,  16'h0001,  12,  2, 16'h0001, 16'h0001};
        tbl[6] = '{1'b1, 16'h0000, 5'd0,  5'd16, 16'hBEEF,  68, 16, 16'h0000, 16'hBEEF};
        tbl[7] = '{1'b1, 16'h1234, 5'd31, 5'd31, 16'hA55A, 132, 32, 16'h1234, 16'hA55A};

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst csn_dac", ni_csn_hp_dac, 1);
        check("rst csn_adc", ni_csn_adc, 1);
        check("rst sclk", ni_sclk, 0);
        check("rst oe", ni_sdio_oe, 0);
        check("rst sdio_o", ni_sdio_o, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
`ifdef NIPCB_SPI_IRQ_EN
        check("rst irq", irq, 0);
`endif
        RESET = 1'b0;
        @(negedge CLK);

        foreach (tbl[i]) begin
            run_cmd(tbl[i], 1'b0, o);
            check_obs($sformatf("vec%0d", i), tbl[i], o);
            @(negedge CLK);
        end

        // Zero-length command: response on the cycle after accept, ready the cycle after that
        v = '{1'b1, 16'hFFFF, 5'd0, 5'd0, 16'hFFFF, 0, 0, 16'h0, 16'h0};
        run_cmd(v, 1'b0, o);
        check("zero rsp_data", o.rsp, 0);
        check("zero csn_low", o.dac_low + o.adc_low, 0);
        check("zero busy", busy, 1);
        @(negedge CLK);
        check("zero ready_next", cmd_ready, 1);

        // Back-to-back ADC commands with cmd_valid held
        base = rsp_cnt;
        v = '{1'b1, 16'h005A, 5'd8, 5'd8, 16'h00C3, 0, 0, 16'h0, 16'h0};
        run_cmd(v, 1'b1, o1);
        check_obs("b2b1", model(v), o1);
        v.slave = 16'h003C;
        run_cmd(v, 1'b0, o2);
        check_obs("b2b2", model(v), o2);
        gap = o2.first_low - o1.last_low - 1;
        check("b2b csn_gap_ok", (gap >= CS_IDLE) ? 1 : 0, 1);
        repeat (6) @(negedge CLK);
        check("b2b rsp_pulses", rsp_cnt - base, 2);

        // Reset during bit 5 of a DAC write
        base = rsp_cnt;
        cmd_dev = 1'b0; cmd_wdata = 16'hFFFF; cmd_wlen = 5'd16; cmd_rlen = 5'd4;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        n_rise = 0;
        for (int i = 0; i < 200 && n_rise < 6; i++) begin
            @(negedge CLK);
            if (ni_sclk) begin
                n_rise++;
                while (ni_sclk === 1'b1) @(negedge CLK);
            end
        end
        check("mid_rst reached_bit5", n_rise, 6);
        check("mid_rst pre csn_dac", ni_csn_hp_dac, 0);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst csn_dac", ni_csn_hp_dac, 1);
        check("mid_rst csn_adc", ni_csn_adc, 1);
        check("mid_rst sclk", ni_sclk, 0);
        check("mid_rst oe", ni_sdio_oe, 0);
        check("mid_rst ready", cmd_ready, 1);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_rst no_rsp", rsp_cnt - base, 0);
        v = '{1'b0, 16'h0F0F, 5'd12, 5'd6, 16'h002B, 0, 0, 16'h0, 16'h0};
        run_cmd(v, 1'b0, o);
        check_obs("post_rst", model(v), o);
        @(negedge CLK);

`ifdef NIPCB_SPI_IRQ_EN
        @(negedge CLK);
        check("irq clear_idle", irq, 0);
        run_cmd(tbl[5], 1'b0, o);
        check("irq with_rsp", irq, 1);
        repeat (2) @(negedge CLK);
        check("irq sticky", irq, 1);
        irq_clr = 1'b1;
        @(negedge CLK);
        check("irq cleared", irq, 0);
        run_cmd(tbl[5], 1'b0, o);
        check("irq rsp_vs_clr", irq, 1);
        @(negedge CLK);
        check("irq set_wins", irq, 1);
        irq_clr = 1'b0;
        @(negedge CLK);
`endif

        // Random commands against the reference model
        for (int i = 0; i < 24; i++) begin
            v.dev   = 1'($urandom_range(0, 1));
            v.wdata = 16'($urandom);
            v.wlen  = 5'($urandom_range(0, 20));
            v.rlen  = 5'($urandom_range(0, 20));
            v.slave = 16'($urandom);
            e = model(v);
            run_cmd(v, 1'b0, o);
            check_obs($sformatf("rnd%0d", i), e, o);
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
